// File: rtl/lcd_timing_ctrl.sv
// LCD raster timing generator: active-low syncs, data enable, pixel source select
// (stream / solid / colour bars / blank) and a saturating stream-underflow counter.
module lcd_timing_ctrl #(
    parameter int H_ACTIVE  = 800,
    parameter int H_SYNC    = 30,
    parameter int H_BP      = 16,
    parameter int H_FP      = 210,
    parameter int V_ACTIVE  = 480,
    parameter int V_SYNC    = 13,
    parameter int V_BP      = 10,
    parameter int V_FP      = 22,
    parameter int FETCH_LAT = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [1:0]  iMODE,
    input  logic [23:0] iSOLID,
    input  logic [23:0] iPIX,
    input  logic        iPIX_VALID,
    output logic        oREQ,
    output logic        oHD,
    output logic        oVD,
    output logic        oDE,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic [10:0] oX,
    output logic [9:0]  oY,
    output logic        oNewFrame,
    output logic        oEndFrame,
    output logic [15:0] oUFLOW_CNT
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_SYNC   = 11'(H_SYNC);
    localparam logic [10:0] X_START  = 11'(H_START);
    localparam logic [10:0] X_END    = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] X_LAST_A = 11'(H_START + H_ACTIVE - 1);
    localparam logic [11:0] XF_START = 12'(H_START);
    localparam logic [11:0] XF_END   = 12'(H_START + H_ACTIVE);
    localparam logic [11:0] XF_LAT   = 12'(FETCH_LAT);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_SYNC   = 10'(V_SYNC);
    localparam logic [9:0]  Y_START  = 10'(V_START);
    localparam logic [9:0]  Y_END    = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  Y_LAST_A = 10'(V_START + V_ACTIVE - 1);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [1:0]  r_mode;
    logic [10:0] r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic        r_hd, r_vd, r_de, r_nf, r_ef;
    logic [23:0] r_rgb;
    logic [10:0] r_ox;
    logic [9:0]  r_oy;
    logic [15:0] r_uflow;

    logic        w_h_act, w_v_act, w_active, w_at_origin, w_fetch_act;
    logic [11:0] w_xf;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_rgb;
    logic        w_uflow;

    assign w_h_act     = (r_x >= X_START) && (r_x < X_END);
    assign w_v_act     = (r_y >= Y_START) && (r_y < Y_END);
    assign w_active    = w_h_act && w_v_act;
    assign w_at_origin = (r_x == 11'd0) && (r_y == 10'd0);

    // Fetch look-ahead is not wrapped: positions past the line end are never active.
    assign w_xf        = {1'b0, r_x} + XF_LAT;
    assign w_fetch_act = (w_xf >= XF_START) && (w_xf < XF_END) && w_v_act;
    assign oREQ        = ~iRST & w_fetch_act & (r_mode == 2'd0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 11'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_mode <= 2'd3;
        end else if (w_at_origin) begin
            r_mode <= iMODE;
        end
    end

    // Bar position tracks the current pixel; cleared outside the active area so each line starts white.
    always_ff @(posedge iCLK) begin
        if (iRST || !w_active) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 11'd1;
        end
    end

    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
    assign w_bar_rgb = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};

    always_comb begin
        w_rgb   = '0;
        w_uflow = 1'b0;
        if (w_active) begin
            case (r_mode)
                2'd0: begin
                    if (iPIX_VALID) w_rgb = iPIX;
                    else            w_uflow = 1'b1;
                end
                2'd1:    w_rgb = iSOLID;
                2'd2:    w_rgb = w_bar_rgb;
                default: w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_hd    <= 1'b1;
            r_vd    <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_nf    <= 1'b0;
            r_ef    <= 1'b0;
            r_uflow <= '0;
        end else begin
            r_hd  <= (r_x >= X_SYNC);
            r_vd  <= (r_y >= Y_SYNC);
            r_de  <= w_active;
            r_rgb <= w_rgb;
            r_ox  <= w_active ? (r_x - X_START) : 11'd0;
            r_oy  <= w_active ? (r_y - Y_START) : 10'd0;
            r_nf  <= w_at_origin;
            r_ef  <= (r_x == X_LAST_A) && (r_y == Y_LAST_A);
            if (w_uflow && (r_uflow != 16'hFFFF)) begin
                r_uflow <= r_uflow + 16'd1;
            end
        end
    end

    assign oHD        = r_hd;
    assign oVD        = r_vd;
    assign oDE        = r_de;
    assign oLCD_R     = r_rgb[23:16];
    assign oLCD_G     = r_rgb[15:8];
    assign oLCD_B     = r_rgb[7:0];
    assign oX         = r_ox;
    assign oY         = r_oy;
    assign oNewFrame  = r_nf;
    assign oEndFrame  = r_ef;
    assign oUFLOW_CNT = r_uflow;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl: small 14x7 raster for timing and modes, plus a
// large-active-area instance that drives the underflow counter into saturation.
module tb_lcd_timing_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small raster instance
    logic        rst;
    logic [1:0]  mode;
    logic [23:0] solid, pix;
    logic        pix_valid;
    logic        oREQ, oHD, oVD, oDE, oNewFrame, oEndFrame;
    logic [7:0]  oLCD_R, oLCD_G, oLCD_B;
    logic [10:0] oX;
    logic [9:0]  oY;
    logic [15:0] oUFLOW_CNT;

    lcd_timing_ctrl #(
        .H_ACTIVE(8), .H_SYNC(2), .H_BP(2), .H_FP(2),
        .V_ACTIVE(4), .V_SYNC(1), .V_BP(1), .V_FP(1), .FETCH_LAT(2)
    ) dut (
        .iCLK(clk), .iRST(rst), .iMODE(mode), .iSOLID(solid), .iPIX(pix),
        .iPIX_VALID(pix_valid), .oREQ(oREQ), .oHD(oHD), .oVD(oVD), .oDE(oDE),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B), .oX(oX), .oY(oY),
        .oNewFrame(oNewFrame), .oEndFrame(oEndFrame), .oUFLOW_CNT(oUFLOW_CNT)
    );

    // 256x256 active instance: one frame of permanent underflow exceeds 16'hFFFF
    logic        rst2;
    logic [1:0]  mode2 = 2'd0;
    logic [23:0] solid2 = 24'h0;
    logic [23:0] pix2 = 24'h0;
    logic        valid2 = 1'b0;
    logic        req2, hd2, vd2, de2, nf2, ef2;
    logic [7:0]  r2, g2, b2;
    logic [10:0] x2;
    logic [9:0]  y2;
    logic [15:0] uf2;

    lcd_timing_ctrl #(
        .H_ACTIVE(256), .H_SYNC(1), .H_BP(1), .H_FP(1),
        .V_ACTIVE(256), .V_SYNC(1), .V_BP(1), .V_FP(1), .FETCH_LAT(1)
    ) dut_sat (
        .iCLK(clk), .iRST(rst2), .iMODE(mode2), .iSOLID(solid2), .iPIX(pix2),
        .iPIX_VALID(valid2), .oREQ(req2), .oHD(hd2), .oVD(vd2), .oDE(de2),
        .oLCD_R(r2), .oLCD_G(g2), .oLCD_B(b2), .oX(x2), .oY(y2),
        .oNewFrame(nf2), .oEndFrame(ef2), .oUFLOW_CNT(uf2)
    );

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int n_tests = 0;
    int n_fail  = 0;

    // ramp source: request index delayed by FETCH_LAT
    bit hist_v   [2];
    int hist_idx [2];
    int req_idx  = 0;
    int drop_lo  = 1;
    int drop_hi  = 0;

    // per-frame capture results
    int waited, de_cnt, hd_bad, vd_bad, de_bad, xy_bad, ef_cnt, ef_idx, nf_extra;
    int req_f, first_req, first_de;
    logic [23:0] rgb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (hist_v[1]) begin
            pix       = 24'(hist_idx[1]);
            pix_valid = !((hist_idx[1] >= drop_lo) && (hist_idx[1] <= drop_hi));
        end else begin
            pix       = 24'h5A5A5A;
            pix_valid = 1'b0;
        end
        hist_v[1]   = hist_v[0];
        hist_idx[1] = hist_idx[0];
        hist_v[0]   = (oREQ === 1'b1);
        hist_idx[0] = req_idx;
        if (oREQ === 1'b1) req_idx++;
    endtask

    // Aligns on oNewFrame, then samples the 98 outputs of one frame (sample i = state i).
    task automatic capture(input int chg_at, input logic [1:0] chg_mode, input logic [23:0] chg_solid);
        int x, y;
        bit act;
        waited = 0;
        while ((oNewFrame !== 1'b1) && (waited < 300)) begin
            step();
            waited++;
        end
        check_eq("nf_found", 32'(oNewFrame), 32'd1);
        rgb_q.delete();
        de_cnt = 0; hd_bad = 0; vd_bad = 0; de_bad = 0; xy_bad = 0;
        ef_cnt = 0; ef_idx = -1; nf_extra = 0; req_f = 0; first_req = -1; first_de = -1;
        for (int i = 0; i < 98; i++) begin
            if (i > 0) step();
            if (i == chg_at) begin
                mode  = chg_mode;
                solid = chg_solid;
            end
            x   = i % 14;
            y   = i / 14;
            act = (x >= 4) && (x < 12) && (y >= 2) && (y < 6);
            if (oHD !== (x >= 2)) hd_bad++;
            if (oVD !== (y >= 1)) vd_bad++;
            if (oDE !== act) de_bad++;
            if (act) begin
                if ((oX !== 11'(x - 4)) || (oY !== 10'(y - 2))) xy_bad++;
            end else if ((oX !== 11'd0) || (oY !== 10'd0) || ({oLCD_R, oLCD_G, oLCD_B} !== 24'd0)) begin
                xy_bad++;
            end
            if (oDE === 1'b1) begin
                rgb_q.push_back({oLCD_R, oLCD_G, oLCD_B});
                de_cnt++;
                if (first_de < 0) first_de = i;
            end
            if (oREQ === 1'b1) begin
                req_f++;
                if (first_req < 0) first_req = i;
            end
            if (oEndFrame === 1'b1) begin
                ef_cnt++;
                ef_idx = i;
            end
            if ((i > 0) && (oNewFrame === 1'b1)) nf_extra++;
        end
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_hd"},    32'(hd_bad),   32'd0);
        check_eq({tag, "_vd"},    32'(vd_bad),   32'd0);
        check_eq({tag, "_de"},    32'(de_bad),   32'd0);
        check_eq({tag, "_xy"},    32'(xy_bad),   32'd0);
        check_eq({tag, "_decnt"}, 32'(de_cnt),   32'd32);
        check_eq({tag, "_efcnt"}, 32'(ef_cnt),   32'd1);
        check_eq({tag, "_efpos"}, 32'(ef_idx),   32'd81);
        check_eq({tag, "_nfx"},   32'(nf_extra), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_hd"},  32'(oHD),        32'd1);
        check_eq({tag, "_vd"},  32'(oVD),        32'd1);
        check_eq({tag, "_de"},  32'(oDE),        32'd0);
        check_eq({tag, "_rgb"}, 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
        check_eq({tag, "_x"},   32'(oX),         32'd0);
        check_eq({tag, "_y"},   32'(oY),         32'd0);
        check_eq({tag, "_nf"},  32'(oNewFrame),  32'd0);
        check_eq({tag, "_ef"},  32'(oEndFrame),  32'd0);
        check_eq({tag, "_uf"},  32'(oUFLOW_CNT), 32'd0);
        check_eq({tag, "_req"}, 32'(oREQ),       32'd0);
    endtask

    function automatic int count_not(input logic [23:0] val);
        int bad = 0;
        foreach (rgb_q[n]) if (rgb_q[n] !== val) bad++;
        return bad;
    endfunction

    initial begin
        rst = 1'b1; rst2 = 1'b1; mode = 2'd3; solid = 24'h0; pix = 24'h0; pix_valid = 1'b0;
        hist_v[0] = 1'b0; hist_v[1] = 1'b0; hist_idx[0] = 0; hist_idx[1] = 0;
        fork
            begin : main_seq
                int bad;
                step(); step();
                check_reset("rst");

                // mode 3 after release
                rst = 1'b0;
                capture(-1, 2'd3, 24'h0);
                check_eq("rel_nf_latency", 32'(waited), 32'd1);
                check_frame("m3");
                check_eq("m3_black", 32'(count_not(24'h0)), 32'd0);
                check_eq("m3_noreq", 32'(req_f), 32'd0);
                capture(-1, 2'd3, 24'h0);
                check_eq("m3_period", 32'(waited), 32'd1);
                check_frame("m3b");

                // mode 0, always-valid ramp
                mode = 2'd0; req_idx = 0;
                capture(-1, 2'd0, 24'h0);
                check_eq("m0_period", 32'(waited), 32'd1);
                check_frame("m0");
                bad = 0;
                foreach (rgb_q[n]) if (rgb_q[n] !== 24'(n)) bad++;
                check_eq("m0_ramp_order", 32'(bad), 32'd0);
                check_eq("m0_req_cnt", 32'(req_f), 32'd32);
                check_eq("m0_req_lead", 32'(first_de - first_req), 32'd3);
                check_eq("m0_uflow", 32'(oUFLOW_CNT), 32'd0);

                // mode 0 with three starved pixels
                drop_lo = 5; drop_hi = 7; req_idx = 0;
                capture(-1, 2'd0, 24'h0);
                check_frame("uf");
                bad = 0;
                foreach (rgb_q[n]) if (rgb_q[n] !== ((n >= 5 && n <= 7) ? 24'h0 : 24'(n))) bad++;
                check_eq("uf_pixels", 32'(bad), 32'd0);
                check_eq("uf_pix6", 32'(rgb_q[6]), 32'd0);
                check_eq("uf_count", 32'(oUFLOW_CNT), 32'd3);
                drop_lo = 1; drop_hi = 0;

                // colour bars
                mode = 2'd2;
                capture(-1, 2'd2, 24'h0);
                check_frame("bar");
                bad = 0;
                foreach (rgb_q[n]) if (rgb_q[n] !== BARS[n % 8]) bad++;
                check_eq("bar_pattern", 32'(bad), 32'd0);
                check_eq("bar_pix2", 32'(rgb_q[2]), 32'h00FFFF);
                check_eq("bar_uflow_hold", 32'(oUFLOW_CNT), 32'd3);

                // blank frame with mid-frame switch to solid
                mode = 2'd3;
                capture(40, 2'd1, 24'h123456);
                check_frame("sw");
                check_eq("sw_still_black", 32'(count_not(24'h0)), 32'd0);
                capture(60, 2'd1, 24'hABCDEF);
                check_frame("sol");
                bad = 0;
                foreach (rgb_q[n]) if (rgb_q[n] !== ((n <= 16) ? 24'h123456 : 24'hABCDEF)) bad++;
                check_eq("sol_pixels", 32'(bad), 32'd0);
                check_eq("sol_uflow_hold", 32'(oUFLOW_CNT), 32'd3);

                // one-clock reset in the middle of an active line
                repeat (51) step();
                check_eq("pre_rst_de", 32'(oDE), 32'd1);
                rst = 1'b1;
                step();
                check_reset("mrst");
                rst = 1'b0;
                capture(-1, 2'd1, 24'hABCDEF);
                check_eq("mrst_nf_latency", 32'(waited), 32'd1);
                check_frame("mrst_f");
                check_eq("mrst_solid", 32'(count_not(24'hABCDEF)), 32'd0);
            end
            begin : sat_seq
                logic [15:0] prev, pre_sat;
                bit seen, found;
                prev = '0; pre_sat = '0; seen = 1'b0; found = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                check_eq("sat_rst_ctl", 32'({req2, hd2, vd2, de2, nf2, ef2}), 32'b011000);
                check_eq("sat_rst_rgb", 32'({r2, g2, b2}), 32'd0);
                check_eq("sat_rst_xy", 32'({x2, y2}), 32'd0);
                check_eq("sat_rst_uf", 32'(uf2), 32'd0);
                rst2 = 1'b0;
                for (int c = 0; c < 70000; c++) begin
                    @(posedge clk); #1;
                    if (!seen && (uf2 == 16'hFFFF)) begin
                        seen    = 1'b1;
                        pre_sat = prev;
                    end
                    prev = uf2;
                    if (ef2 === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                check_eq("sat_endframe_seen", 32'(found), 32'd1);
                check_eq("sat_value", 32'(uf2), 32'hFFFF);
                check_eq("sat_prev", 32'(pre_sat), 32'hFFFE);
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
